// File: rtl/credit_pkg.sv
// Shared definitions for the credit debtor slice.
// Provides the default parameter values, a constant clog2 helper, the derived
// channel-index width helper and the request FSM state type.
package credit_pkg;

    localparam int unsigned DEF_CHANNELS      = 4;
    localparam int unsigned DEF_WIDTH         = 8;
    localparam int unsigned DEF_TRANCHE_WIDTH = 4;
    localparam int unsigned DEF_LOW_WATER     = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel index width; never zero so CHANNELS=1 still has a usable bus.
    function automatic int unsigned chw(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_e;

endpackage

// File: rtl/debtor_array_if.sv
// Creditor-facing bus of the debtor: the shared lend port (creditor -> debtor)
// and the credit request valid/ready handshake (debtor -> creditor).
//   lend, lend_channel, tranche : tranche delivery from the creditor
//   req_valid, req_channel      : credit request from the debtor
//   req_ready                   : creditor accepts the request
// master = debtor side, slave = creditor side.
interface debtor_array_if #(
    parameter int unsigned CHW           = 2,
    parameter int unsigned TRANCHE_WIDTH = 4
);
    logic                     lend;
    logic [CHW-1:0]           lend_channel;
    logic [TRANCHE_WIDTH-1:0] tranche;
    logic                     req_valid;
    logic [CHW-1:0]           req_channel;
    logic                     req_ready;

    modport master (
        input  lend, lend_channel, tranche, req_ready,
        output req_valid, req_channel
    );

    modport slave (
        output lend, lend_channel, tranche, req_ready,
        input  req_valid, req_channel
    );
endinterface

// File: rtl/credit_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : per-channel request vector
//   i_ptr   : channel where the search starts
//   o_grant : one-hot of the first requesting channel at or after i_ptr
//   o_idx   : index of the granted channel (0 when nothing requests)
module credit_rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CHW      = 2
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [CHW-1:0]      i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [CHW-1:0]      o_idx
);
    always_comb begin
        int unsigned w_j;
        logic        w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_j = (int'(i_ptr) + i) % CHANNELS;
            if (!w_found && i_req[w_j]) begin
                w_found       = 1'b1;
                o_grant[w_j]  = 1'b1;
                o_idx         = CHW'(w_j);
            end
        end
    end
endmodule

// File: rtl/debtor_array.sv
// Multi-channel credit debtor. One saturating credit counter per channel is
// refilled through the shared lend port and drained by per-channel payback
// pulses. Channels below LOW_WATER that have no request outstanding are
// requested from the creditor one at a time, round-robin.
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : lend port in, credit request handshake out
//   payback        : per-channel consume-one-credit pulse
//   owing          : bit c set while credit[c] != 0
//   credit_flat    : counters, channel c at [c*WIDTH +: WIDTH]
//   err_overflow   : sticky saturation flags
//   err_underflow  : sticky payback-at-zero flags
//   err_badchan    : sticky lend to an out-of-range channel
//   err_clear      : clears all sticky flags
//   error          : OR of all sticky flags
module debtor_array
    import credit_pkg::*;
#(
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned TRANCHE_WIDTH = DEF_TRANCHE_WIDTH,
    parameter int unsigned LOW_WATER     = DEF_LOW_WATER,
    parameter int unsigned CHW           = chw(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    debtor_array_if.master            bus,
    input  logic [CHANNELS-1:0]       payback,
    output logic [CHANNELS-1:0]       owing,
    output logic [CHANNELS*WIDTH-1:0] credit_flat,
    output logic [CHANNELS-1:0]       err_overflow,
    output logic [CHANNELS-1:0]       err_underflow,
    output logic                      err_badchan,
    input  logic                      err_clear,
    output logic                      error
);
    localparam logic [WIDTH:0] C_MAX = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH-1:0]    r_credit [CHANNELS];
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] r_unf;
    logic                r_bad;
    logic [CHW-1:0]      r_ptr;
    logic [CHW-1:0]      r_req_channel;
    req_state_e          r_state;
    req_state_e          w_state_next;

    logic [WIDTH-1:0]    w_credit_next [CHANNELS];
    logic [CHANNELS-1:0] w_ovf_evt;
    logic [CHANNELS-1:0] w_unf_evt;
    logic [CHANNELS-1:0] w_lend_hit;
    logic [CHANNELS-1:0] w_hs_vec;
    logic [CHANNELS-1:0] w_hungry;
    logic [CHANNELS-1:0] w_grant;
    logic [CHW-1:0]      w_pick;
    logic                w_lend_ok;
    logic                w_lend_bad;
    logic                w_hs;
    logic                w_any;

    assign w_lend_ok  = bus.lend && (int'(bus.lend_channel) < CHANNELS);
    assign w_lend_bad = bus.lend && !w_lend_ok;
    assign w_hs       = (r_state == ST_REQ) && bus.req_ready;
    assign w_any      = |w_grant;

    // Counter arithmetic in WIDTH+1 bits so the saturation test sees the carry.
    // A simultaneous lend always covers a payback, so underflow needs add == 0.
    always_comb begin
        logic [WIDTH:0] w_add;
        logic [WIDTH:0] w_sum;
        w_ovf_evt  = '0;
        w_unf_evt  = '0;
        w_lend_hit = '0;
        w_hs_vec   = '0;
        w_hungry   = '0;
        w_add      = '0;
        w_sum      = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_lend_hit[c] = w_lend_ok && (int'(bus.lend_channel) == c);
            w_hs_vec[c]   = w_hs && (int'(r_req_channel) == c);
            w_hungry[c]   = (int'(r_credit[c]) < LOW_WATER) && !r_pending[c];
            w_add = w_lend_hit[c] ? {{(WIDTH+1-TRANCHE_WIDTH){1'b0}}, bus.tranche} : '0;
            w_sum = {1'b0, r_credit[c]} + w_add - (WIDTH+1)'(payback[c]);
            w_credit_next[c] = w_sum[WIDTH-1:0];
            if (payback[c] && (w_add == '0) && (r_credit[c] == '0)) begin
                w_credit_next[c] = '0;
                w_unf_evt[c]     = 1'b1;
            end else if (w_sum > C_MAX) begin
                w_credit_next[c] = C_MAX[WIDTH-1:0];
                w_ovf_evt[c]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_credit[c] <= '0;
            end
            r_pending <= '0;
            r_ovf     <= '0;
            r_unf     <= '0;
            r_bad     <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_credit[c] <= w_credit_next[c];
            end
            // Handshake wins over a same-cycle lend to the same channel.
            r_pending <= (r_pending & ~w_lend_hit) | w_hs_vec;
            // New events win over err_clear.
            r_ovf     <= (err_clear ? '0 : r_ovf) | w_ovf_evt;
            r_unf     <= (err_clear ? '0 : r_unf) | w_unf_evt;
            r_bad     <= (err_clear ? 1'b0 : r_bad) | w_lend_bad;
        end
    end

    credit_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CHW      (CHW)
    ) u_arb (
        .i_req   (w_hungry),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any)         w_state_next = ST_REQ;
            ST_REQ:  if (bus.req_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // The channel is captured once in IDLE and held through REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_channel <= '0;
            r_ptr         <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any) begin
                r_req_channel <= w_pick;
            end
            if (w_hs) begin
                r_ptr <= (int'(r_req_channel) == CHANNELS - 1) ? '0
                                                               : r_req_channel + 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_valid   = (r_state == ST_REQ);
        bus.req_channel = r_req_channel;
        owing           = '0;
        credit_flat     = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            owing[c]                      = |r_credit[c];
            credit_flat[c*WIDTH +: WIDTH] = r_credit[c];
        end
        err_overflow  = r_ovf;
        err_underflow = r_unf;
        err_badchan   = r_bad;
        error         = (|r_ovf) | (|r_unf) | r_bad;
    end

endmodule
